// File: rtl/sram_arb_pkg.sv
// Shared constants and helpers for the 1W/1R banked SRAM arbiter.
// Defaults match the 4096x8 sram_b macro.
package sram_arb_pkg;

    localparam int NWR_DEF       = 2;
    localparam int NRD_DEF       = 2;
    localparam int ABITS_DEF     = 12;
    localparam int DBITS_DEF     = 8;
    localparam int STALL_MAX_DEF = 4;

    // Never returns 0, so single-client indices still get a 1-bit port.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: lowest index at or after the pointer wins, wrapping at N.
// The pointer moves past the winner only when the parent commits the grant.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic                  advance,
    output logic [N-1:0]          gnt,
    output logic [clog2(N)-1:0]   idx,
    output logic                  valid
);

    localparam int IW = clog2(N);

    logic [IW-1:0] ptr_q, ptr_d;

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        ptr_d = ptr_q;
        // Scan from farthest to nearest so the nearest requester overwrites.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap(int'(ptr_q) + k)]) begin
                idx   = IW'(wrap(int'(ptr_q) + k));
                valid = 1'b1;
            end
        end
        if (valid) gnt[idx] = 1'b1;
        if (advance && valid) ptr_d = (int'(idx) == N - 1) ? '0 : idx + IW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sram_b_1w1r_arbiter.sv
// Shares one 1W/1R sram_b among NWR writers and NRD readers with independent round-robin,
// keeping same-address write/read pairs off the memory and bounding read starvation.
module sram_b_1w1r_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NWR       = NWR_DEF,
    parameter int NRD       = NRD_DEF,
    parameter int ABITS     = ABITS_DEF,
    parameter int DBITS     = DBITS_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NWR-1:0]          wr_req,
    input  logic [NWR*ABITS-1:0]    wr_addr,
    input  logic [NWR*DBITS-1:0]    wr_data,
    input  logic [NWR*DBITS-1:0]    wr_mask,
    output logic [NWR-1:0]          wr_gnt,
    input  logic [NRD-1:0]          rd_req,
    input  logic [NRD*ABITS-1:0]    rd_addr,
    output logic [NRD-1:0]          rd_gnt,
    output logic                    rd_rvalid,
    output logic [clog2(NRD)-1:0]   rd_rid,
    output logic [DBITS-1:0]        rd_rdata,
    output logic                    MEM_CE0,
    output logic [ABITS-1:0]        MEM_A0,
    output logic [DBITS-1:0]        MEM_D0,
    output logic                    MEM_WE0,
    output logic [DBITS-1:0]        MEM_WEM0,
    output logic                    MEM_CE1,
    output logic [ABITS-1:0]        MEM_A1,
    input  logic [DBITS-1:0]        MEM_Q1
);

    localparam int WIW = clog2(NWR);
    localparam int RIW = clog2(NRD);
    localparam int DCW = clog2(STALL_MAX + 1);

    logic [NWR-1:0]   wr_sel_gnt;
    logic [WIW-1:0]   wr_idx;
    logic             wr_any, wr_go;
    logic [NRD-1:0]   rd_sel_gnt;
    logic [RIW-1:0]   rd_idx;
    logic             rd_any, rd_go;

    logic [ABITS-1:0] wr_sel_addr, rd_sel_addr;
    logic [DBITS-1:0] wr_sel_data, wr_sel_mask;
    logic             collide, stall_wr;

    logic [DCW-1:0]   defer_cnt_q, defer_cnt_d;
    logic             rvalid_q, rvalid_d;
    logic [RIW-1:0]   rid_q, rid_d;
    logic [DBITS-1:0] rdata_q, rdata_d;

    rr_arbiter #(.N(NWR)) u_wr_arb (
        .clk     (CLK),
        .rst     (RST),
        .req     (wr_req),
        .advance (wr_go),
        .gnt     (wr_sel_gnt),
        .idx     (wr_idx),
        .valid   (wr_any)
    );

    rr_arbiter #(.N(NRD)) u_rd_arb (
        .clk     (CLK),
        .rst     (RST),
        .req     (rd_req),
        .advance (rd_go),
        .gnt     (rd_sel_gnt),
        .idx     (rd_idx),
        .valid   (rd_any)
    );

    always_comb begin
        wr_sel_addr = '0;
        wr_sel_data = '0;
        wr_sel_mask = '0;
        rd_sel_addr = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wr_idx == WIW'(i)) begin
                wr_sel_addr = wr_addr[i*ABITS +: ABITS];
                wr_sel_data = wr_data[i*DBITS +: DBITS];
                wr_sel_mask = wr_mask[i*DBITS +: DBITS];
            end
        end
        for (int i = 0; i < NRD; i++) begin
            if (rd_idx == RIW'(i)) rd_sel_addr = rd_addr[i*ABITS +: ABITS];
        end

        // A collision defers the read until it has waited STALL_MAX times, then the write yields.
        collide  = wr_any && rd_any && (wr_sel_addr == rd_sel_addr);
        stall_wr = collide && (defer_cnt_q == DCW'(STALL_MAX));
        wr_go    = !RST && wr_any && !stall_wr;
        rd_go    = !RST && rd_any && (!collide || stall_wr);

        defer_cnt_d = defer_cnt_q;
        if (rd_go)        defer_cnt_d = '0;
        else if (collide) defer_cnt_d = defer_cnt_q + DCW'(1);

        wr_gnt   = wr_go ? wr_sel_gnt : '0;
        MEM_CE0  = wr_go;
        MEM_WE0  = wr_go;
        MEM_A0   = wr_go ? wr_sel_addr : '0;
        MEM_D0   = wr_go ? wr_sel_data : '0;
        MEM_WEM0 = wr_go ? wr_sel_mask : '0;

        rd_gnt   = rd_go ? rd_sel_gnt : '0;
        MEM_CE1  = rd_go;
        MEM_A1   = rd_go ? rd_sel_addr : '0;

        // Data passes straight through while valid and is held afterwards.
        rd_rdata = rvalid_q ? MEM_Q1 : rdata_q;
        rdata_d  = rd_rdata;
        rvalid_d = rd_go;
        rid_d    = rd_go ? rd_idx : rid_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            defer_cnt_q <= '0;
            rvalid_q    <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
        end else begin
            defer_cnt_q <= defer_cnt_d;
            rvalid_q    <= rvalid_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rd_rvalid = rvalid_q;
    assign rd_rid    = rid_q;

endmodule

// File: tb/tb_sram_b_1w1r_arbiter.sv
// Randomized and directed bench for sram_b_1w1r_arbiter against a round-robin/collision
// reference model, with a behavioural 1W/1R SRAM on the memory ports.
module tb_sram_b_1w1r_arbiter;

    localparam int NWR = 2, NRD = 2, ABITS = 12, DBITS = 8, STALL_MAX = 4;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [NWR-1:0]        wr_req;
    logic [NWR*ABITS-1:0]  wr_addr;
    logic [NWR*DBITS-1:0]  wr_data;
    logic [NWR*DBITS-1:0]  wr_mask;
    logic [NWR-1:0]        wr_gnt;
    logic [NRD-1:0]        rd_req;
    logic [NRD*ABITS-1:0]  rd_addr;
    logic [NRD-1:0]        rd_gnt;
    logic                  rd_rvalid;
    logic [0:0]            rd_rid;
    logic [DBITS-1:0]      rd_rdata;
    logic                  MEM_CE0, MEM_WE0, MEM_CE1;
    logic [ABITS-1:0]      MEM_A0, MEM_A1;
    logic [DBITS-1:0]      MEM_D0, MEM_WEM0, MEM_Q1;

    always #5 CLK = ~CLK;

    sram_b_1w1r_arbiter #(
        .NWR(NWR), .NRD(NRD), .ABITS(ABITS), .DBITS(DBITS), .STALL_MAX(STALL_MAX)
    ) dut (
        .CLK(CLK), .RST(RST),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_rvalid(rd_rvalid), .rd_rid(rd_rid), .rd_rdata(rd_rdata),
        .MEM_CE0(MEM_CE0), .MEM_A0(MEM_A0), .MEM_D0(MEM_D0), .MEM_WE0(MEM_WE0), .MEM_WEM0(MEM_WEM0),
        .MEM_CE1(MEM_CE1), .MEM_A1(MEM_A1), .MEM_Q1(MEM_Q1)
    );

    // Behavioural sram_b: synchronous read, masked write (mask bit 1 = write that bit).
    logic [DBITS-1:0] sram [0:4095];
    always @(posedge CLK) begin
        if (MEM_CE1) MEM_Q1 <= sram[MEM_A1];
        if (MEM_CE0 && MEM_WE0) sram[MEM_A0] = (sram[MEM_A0] & ~MEM_WEM0) | (MEM_D0 & MEM_WEM0);
    end

    // Reference model state.
    logic [DBITS-1:0] ref_mem [0:4095];
    int               wptr, rptr, defer, last_wg, last_rg, exp_rid;
    bit               exp_rv;
    logic [DBITS-1:0] exp_rdata;
    int               n_vec, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] req, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (req[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        wptr = 0; rptr = 0; defer = 0; last_wg = -1; last_rg = -1;
        exp_rv = 1'b0; exp_rid = 0; exp_rdata = '0;
    endtask

    task automatic set_wr(input int i, input bit r, input int a, input int d, input int m);
        wr_req[i] = r;
        wr_addr[i*ABITS +: ABITS] = ABITS'(a);
        wr_data[i*DBITS +: DBITS] = DBITS'(d);
        wr_mask[i*DBITS +: DBITS] = DBITS'(m);
    endtask

    task automatic set_rd(input int i, input bit r, input int a);
        rd_req[i] = r;
        rd_addr[i*ABITS +: ABITS] = ABITS'(a);
    endtask

    // Called just after a falling edge with inputs driven: checks this cycle, advances the model.
    task automatic step();
        int ws, rs, wg, rg;
        logic [ABITS-1:0] wa, ra;
        logic [DBITS-1:0] wd, wm;
        #1;
        ws = pick(8'(wr_req), wptr, NWR);
        rs = pick(8'(rd_req), rptr, NRD);
        wa = '0; ra = '0; wd = '0; wm = '0;
        if (ws >= 0) begin
            wa = wr_addr[ws*ABITS +: ABITS];
            wd = wr_data[ws*DBITS +: DBITS];
            wm = wr_mask[ws*DBITS +: DBITS];
        end
        if (rs >= 0) ra = rd_addr[rs*ABITS +: ABITS];
        wg = -1; rg = -1;
        if (ws >= 0 && rs >= 0 && wa == ra) begin
            if (defer == STALL_MAX) rg = rs;
            else begin
                wg = ws;
                defer++;
            end
        end else begin
            wg = ws;
            rg = rs;
        end

        check("wr_gnt", 32'(wr_gnt), (wg >= 0) ? (1 << wg) : 0);
        check("rd_gnt", 32'(rd_gnt), (rg >= 0) ? (1 << rg) : 0);
        check("mem_ce0", 32'(MEM_CE0), (wg >= 0) ? 1 : 0);
        check("mem_ce1", 32'(MEM_CE1), (rg >= 0) ? 1 : 0);
        if (wg >= 0) begin
            check("mem_we0", 32'(MEM_WE0), 1);
            check("mem_a0", 32'(MEM_A0), 32'(wa));
            check("mem_d0", 32'(MEM_D0), 32'(wd));
            check("mem_wem0", 32'(MEM_WEM0), 32'(wm));
        end
        if (rg >= 0) check("mem_a1", 32'(MEM_A1), 32'(ra));
        check("rd_rvalid", 32'(rd_rvalid), 32'(exp_rv));
        if (exp_rv) check("rd_rid", 32'(rd_rid), exp_rid);
        check("rd_rdata", 32'(rd_rdata), 32'(exp_rdata));

        if (rg >= 0) begin
            rptr      = (rg + 1) % NRD;
            defer     = 0;
            exp_rid   = rg;
            exp_rdata = ref_mem[ra];
        end
        if (wg >= 0) begin
            wptr        = (wg + 1) % NWR;
            ref_mem[wa] = (ref_mem[wa] & ~wm) | (wd & wm);
        end
        exp_rv  = (rg >= 0);
        last_wg = wg;
        last_rg = rg;
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        for (int i = 0; i < 4096; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        RST = 1'b1;
        wr_req = '1; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_req = '1; rd_addr = {12'd1, 12'd2};

        // Reset state: grants and chip enables forced low even with requests pending.
        #2;
        check("rst_wr_gnt", 32'(wr_gnt), 0);
        check("rst_rd_gnt", 32'(rd_gnt), 0);
        check("rst_ce0", 32'(MEM_CE0), 0);
        check("rst_ce1", 32'(MEM_CE1), 0);
        check("rst_rvalid", 32'(rd_rvalid), 0);
        check("rst_rid", 32'(rd_rid), 0);
        check("rst_rdata", 32'(rd_rdata), 0);
        wr_req = '0; rd_req = '0;
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;

        // Two writers contend: grants alternate.
        set_wr(0, 1, 5, 'h11, 'hff);
        set_wr(1, 1, 6, 'h22, 'hff);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_wgnt_seq", 32'(wr_gnt), (k % 2 == 0) ? 1 : 2);
            @(negedge CLK);
        end
        check("t1_mem5", 32'(sram[5]), 'h11);
        check("t1_mem6", 32'(sram[6]), 'h22);
        set_wr(0, 0, 0, 0, 0);
        set_wr(1, 0, 0, 0, 0);

        // Write then read back one cycle after the grant.
        set_wr(0, 1, 5, 'hA5, 'hff);
        step();
        @(negedge CLK);
        set_wr(0, 0, 0, 0, 0);
        set_rd(0, 1, 5);
        step();
        check("t2_rgnt", 32'(rd_gnt), 1);
        @(negedge CLK);
        set_rd(0, 0, 0);
        step();
        check("t2_rvalid", 32'(rd_rvalid), 1);
        check("t2_rid", 32'(rd_rid), 0);
        check("t2_rdata", 32'(rd_rdata), 'hA5);
        @(negedge CLK);

        // Same-address write and read: write wins, read follows and sees new data.
        set_wr(0, 1, 7, 'h3C, 'hff);
        set_rd(0, 1, 7);
        step();
        check("t3_rgnt_defer", 32'(rd_gnt), 0);
        check("t3_wgnt", 32'(wr_gnt), 1);
        @(negedge CLK);
        set_wr(0, 0, 0, 0, 0);
        step();
        check("t3_rgnt_next", 32'(rd_gnt), 1);
        @(negedge CLK);
        set_rd(0, 0, 0);
        step();
        check("t3_rdata", 32'(rd_rdata), 'h3C);
        @(negedge CLK);

        // Persistent collision: four deferrals, then the write yields.
        set_wr(0, 1, 9, 'h5A, 'hff);
        set_rd(1, 1, 9);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_rgnt", 32'(rd_gnt), (k < 4) ? 0 : 2);
            check("t4_wgnt", 32'(wr_gnt), (k < 4) ? 1 : 0);
            @(negedge CLK);
        end
        set_wr(0, 0, 0, 0, 0);
        set_rd(1, 0, 0);

        // Both readers every cycle: one return per cycle, ids alternate.
        set_rd(0, 1, 100);
        set_rd(1, 1, 101);
        for (int k = 0; k < 6; k++) begin
            step();
            if (k > 0) begin
                check("t5_rvalid", 32'(rd_rvalid), 1);
                check("t5_rid", 32'(rd_rid), (k - 1) % 2);
            end
            @(negedge CLK);
        end
        set_rd(0, 0, 0);
        set_rd(1, 0, 0);

        // Random traffic on a small address window to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NWR; i++) begin
                if (last_wg == i) wr_req[i] = 1'b0;
                if (!wr_req[i] && $urandom_range(0, 99) < 50)
                    set_wr(i, 1, $urandom_range(0, 7), $urandom, $urandom);
            end
            for (int i = 0; i < NRD; i++) begin
                if (last_rg == i) rd_req[i] = 1'b0;
                if (!rd_req[i] && $urandom_range(0, 99) < 50)
                    set_rd(i, 1, $urandom_range(0, 7));
            end
            step();
            @(negedge CLK);
        end

        // Reset between grant and return drops the read.
        wr_req = '0;
        rd_req = '0;
        set_rd(0, 1, 3);
        step();
        check("t6_rgnt", 32'(rd_gnt), (rptr == 1) ? 1 : 0);
        set_wr(0, 1, 20, 'h77, 'hff);
        set_wr(1, 1, 21, 'h88, 'hff);
        set_rd(0, 1, 30);
        set_rd(1, 1, 31);
        @(posedge CLK);
        #1;
        check("t6_pre_rvalid", 32'(rd_rvalid), 1);
        RST = 1'b1;
        #1;
        check("t6_rvalid", 32'(rd_rvalid), 0);
        check("t6_wgnt_rst", 32'(wr_gnt), 0);
        check("t6_rgnt_rst", 32'(rd_gnt), 0);
        check("t6_ce0", 32'(MEM_CE0), 0);
        check("t6_ce1", 32'(MEM_CE1), 0);
        check("t6_rdata", 32'(rd_rdata), 0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        step();
        check("t6_wgnt_ptr0", 32'(wr_gnt), 1);
        check("t6_rgnt_ptr0", 32'(rd_gnt), 1);
        @(negedge CLK);
        wr_req = '0;
        rd_req = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
